// File: rtl/pi_arb.sv
// Priority-interrupt arbiter for the EBOX: holds the 7-level PI state, picks the
// highest eligible level and sequences the EBUS function/grant handshake with CON.
module pi_arb #(
  parameter int TIMEOUT  = 16,
  parameter int REQ_SYNC = 2
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        CONO_PI,
  input  logic [0:35] EBUS_DATA,
  input  logic [1:7]  IO_REQ,
  input  logic        IO_ACK,
  input  logic        PI_DISABLE,
  input  logic        PI_CYCLE,
  input  logic        SET_PIH,
  input  logic        PI_DISMISS,
  input  logic        EBUS_REL,
  output logic        READY,
  output logic [0:2]  PI_LEVEL,
  output logic        EBUS_CP_GRANT,
  output logic        EXT_TRAN_REC,
  output logic        NO_RESP,
  output logic        PI_ON,
  output logic [1:7]  LEVEL_ON,
  output logic [1:7]  PIR,
  output logic [1:7]  PIH
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RDY,
    S_FUNC,
    S_WREL
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_level, w_level_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_ready, r_grant, r_etr, r_no_resp, r_pi_on;
  logic [1:7] r_level_on, r_pir, r_pih;
  logic [1:7] r_req_sync [REQ_SYNC];

  logic [1:7] w_req, w_sel, w_elig;
  logic [1:7] w_pir_nxt, w_pih_nxt, w_level_on_nxt;
  logic [2:0] w_pih_first, w_elig_first;
  logic [3:0] w_pih_limit;
  logic       w_cono22, w_lvl_elig, w_etr_nxt, w_timeout;
  logic       w_pi_on_nxt, w_no_resp_nxt;
  logic       w_unused;

  // Lowest-numbered set bit (highest priority) as a level number, 0 when empty.
  function automatic logic [2:0] f_first(input logic [1:7] v);
    f_first = 3'd0;
    for (int n = 7; n >= 1; n--) begin
      if (v[n]) f_first = 3'(n);
    end
  endfunction

  function automatic logic [1:7] f_onehot(input logic [2:0] lvl);
    for (int n = 1; n <= 7; n++) begin
      f_onehot[n] = (lvl == 3'(n));
    end
  endfunction

  assign w_sel    = EBUS_DATA[29:35];
  assign w_cono22 = CONO_PI & EBUS_DATA[22];
  assign w_unused = ^EBUS_DATA[0:21];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < REQ_SYNC; i++) r_req_sync[i] <= '0;
    end else begin
      r_req_sync[0] <= IO_REQ;
      for (int i = 1; i < REQ_SYNC; i++) r_req_sync[i] <= r_req_sync[i-1];
    end
  end

  assign w_req = r_req_sync[REQ_SYNC-1];

  always_comb begin
    w_elig      = '0;
    w_lvl_elig  = 1'b0;
    w_pih_first = f_first(r_pih);
    w_pih_limit = (w_pih_first == 3'd0) ? 4'd8 : {1'b0, w_pih_first};
    for (int n = 1; n <= 7; n++) begin
      w_elig[n] = (w_req[n] | r_pir[n]) & r_level_on[n] & r_pi_on & (4'(n) < w_pih_limit);
    end
    for (int n = 1; n <= 7; n++) begin
      if (r_level == 3'(n)) w_lvl_elig = w_elig[n];
    end
    w_elig_first = f_first(w_elig);
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_cnt_nxt   = r_cnt;
    w_etr_nxt   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_level_nxt = 3'd0;
        if (|w_elig && !PI_DISABLE) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        if (|w_elig) begin
          w_state_nxt = S_RDY;
          w_level_nxt = w_elig_first;
        end else begin
          w_state_nxt = S_IDLE;
          w_level_nxt = 3'd0;
        end
      end
      S_RDY: begin
        if (PI_CYCLE) begin
          w_state_nxt = S_FUNC;
          w_cnt_nxt   = 8'd0;
        end else if (!w_lvl_elig) begin
          w_state_nxt = S_IDLE;
          w_level_nxt = 3'd0;
        end else if (w_elig_first < r_level) begin
          w_state_nxt = S_ARB;
        end
      end
      S_FUNC: begin
        if (IO_ACK) begin
          w_etr_nxt   = 1'b1;
          w_state_nxt = S_WREL;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_WREL;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_WREL: begin
        if (EBUS_REL) begin
          w_state_nxt = S_IDLE;
          w_level_nxt = 3'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_level_nxt = 3'd0;
      end
    endcase
    if (w_cono22) begin
      w_state_nxt = S_IDLE;
      w_level_nxt = 3'd0;
      w_cnt_nxt   = 8'd0;
      w_etr_nxt   = 1'b0;
      w_timeout   = 1'b0;
    end
  end

  // Dismiss is applied before set, so a same-cycle pair retires the old level first.
  always_comb begin
    w_pir_nxt      = r_pir;
    w_level_on_nxt = r_level_on;
    w_pi_on_nxt    = r_pi_on;
    w_pih_nxt      = r_pih;
    if (CONO_PI) begin
      if (EBUS_DATA[23]) w_pir_nxt = '0;
      if (EBUS_DATA[24]) w_pir_nxt = w_pir_nxt | w_sel;
      if (EBUS_DATA[25]) w_level_on_nxt = w_level_on_nxt | w_sel;
      if (EBUS_DATA[26]) w_level_on_nxt = w_level_on_nxt & ~w_sel;
      if (EBUS_DATA[28]) w_pi_on_nxt = 1'b1;
      if (EBUS_DATA[27]) w_pi_on_nxt = 1'b0;
    end
    if (PI_DISMISS) w_pih_nxt = w_pih_nxt & ~f_onehot(w_pih_first);
    if (SET_PIH && (r_level != 3'd0)) begin
      w_pih_nxt = w_pih_nxt | f_onehot(r_level);
      w_pir_nxt = w_pir_nxt & ~f_onehot(r_level);
    end
    w_no_resp_nxt = r_no_resp | w_timeout;
    if (w_cono22) begin
      w_pir_nxt      = '0;
      w_level_on_nxt = '0;
      w_pi_on_nxt    = 1'b0;
      w_pih_nxt      = '0;
      w_no_resp_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_level    <= 3'd0;
      r_cnt      <= 8'd0;
      r_ready    <= 1'b0;
      r_grant    <= 1'b0;
      r_etr      <= 1'b0;
      r_no_resp  <= 1'b0;
      r_pi_on    <= 1'b0;
      r_level_on <= '0;
      r_pir      <= '0;
      r_pih      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ready    <= (w_state_nxt == S_RDY);
      r_grant    <= (w_state_nxt == S_FUNC) || (w_state_nxt == S_WREL);
      r_etr      <= w_etr_nxt;
      r_no_resp  <= w_no_resp_nxt;
      r_pi_on    <= w_pi_on_nxt;
      r_level_on <= w_level_on_nxt;
      r_pir      <= w_pir_nxt;
      r_pih      <= w_pih_nxt;
    end
  end

  assign READY         = r_ready;
  assign PI_LEVEL      = r_level;
  assign EBUS_CP_GRANT = r_grant;
  assign EXT_TRAN_REC  = r_etr;
  assign NO_RESP       = r_no_resp;
  assign PI_ON         = r_pi_on;
  assign LEVEL_ON      = r_level_on;
  assign PIR           = r_pir;
  assign PIH           = r_pih;

endmodule

// File: tb/tb_pi_arb.sv
// Bench for pi_arb: directed handshake scenarios plus randomized CONO_PI decode and
// priority selection checked against a level-by-level reference model.
module tb_pi_arb;

  localparam logic [22:28] C22 = 7'b1000000;
  localparam logic [22:28] C24 = 7'b0010000;
  localparam logic [22:28] C25 = 7'b0001000;
  localparam logic [22:28] C28 = 7'b0000001;
  localparam logic [1:7]   ALL = 7'b1111111;

  logic        clk = 1'b0;
  logic        RESET, CONO_PI, IO_ACK, PI_DISABLE, PI_CYCLE, SET_PIH, PI_DISMISS, EBUS_REL;
  logic [0:35] EBUS_DATA;
  logic [1:7]  IO_REQ;
  logic        READY, EBUS_CP_GRANT, EXT_TRAN_REC, NO_RESP, PI_ON;
  logic [0:2]  PI_LEVEL;
  logic [1:7]  LEVEL_ON, PIR, PIH;

  int n_vec = 0;
  int n_err = 0;

  pi_arb #(.TIMEOUT(16), .REQ_SYNC(2)) dut (
    .clk(clk), .RESET(RESET), .CONO_PI(CONO_PI), .EBUS_DATA(EBUS_DATA), .IO_REQ(IO_REQ),
    .IO_ACK(IO_ACK), .PI_DISABLE(PI_DISABLE), .PI_CYCLE(PI_CYCLE), .SET_PIH(SET_PIH),
    .PI_DISMISS(PI_DISMISS), .EBUS_REL(EBUS_REL), .READY(READY), .PI_LEVEL(PI_LEVEL),
    .EBUS_CP_GRANT(EBUS_CP_GRANT), .EXT_TRAN_REC(EXT_TRAN_REC), .NO_RESP(NO_RESP),
    .PI_ON(PI_ON), .LEVEL_ON(LEVEL_ON), .PIR(PIR), .PIH(PIH)
  );

  always #5 clk = ~clk;

  function automatic logic [1:7] lvl(input int n);
    lvl = '0;
    lvl[n] = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cono(input logic [22:28] c, input logic [1:7] sel);
    EBUS_DATA = '0;
    EBUS_DATA[22:28] = c;
    EBUS_DATA[29:35] = sel;
    CONO_PI = 1'b1;
    tick();
    CONO_PI = 1'b0;
    EBUS_DATA = {4'($urandom), 32'($urandom)};
  endtask

  task automatic do_reset();
    IO_REQ = '0; IO_ACK = 0; PI_DISABLE = 0; PI_CYCLE = 0; SET_PIH = 0;
    PI_DISMISS = 0; EBUS_REL = 0; CONO_PI = 0;
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    tick();
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (i < budget) tick();
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({READY, PI_LEVEL, EBUS_CP_GRANT, EXT_TRAN_REC, NO_RESP, PI_ON, LEVEL_ON, PIR, PIH} !== '0) begin
      n_err++;
      $display("FAIL reset_held: outputs=%b want all 0",
               {READY, PI_LEVEL, EBUS_CP_GRANT, EXT_TRAN_REC, NO_RESP, PI_ON, LEVEL_ON, PIR, PIH});
    end
    RESET = 1'b0;
    tick(); tick();
    n_vec++;
    if ({READY, PI_LEVEL, EBUS_CP_GRANT, PI_ON, LEVEL_ON, PIR, PIH} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: outputs=%b want all 0", {READY, PI_LEVEL, EBUS_CP_GRANT, PI_ON, LEVEL_ON, PIR, PIH});
    end
  endtask

  task automatic test_handshake();
    bit early = 1'b0;
    bit etr_extra = 1'b0;
    do_reset();
    cono(C25 | C28, ALL);
    IO_REQ = lvl(3);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (READY !== 1'b0) early = 1'b1;
    end
    tick();
    n_vec++;
    if (early || READY !== 1'b1) begin
      n_err++;
      $display("FAIL hs_latency: early=%b READY@4=%b want early=0 READY=1", early, READY);
    end
    n_vec++;
    if (PI_LEVEL !== 3'd3) begin n_err++; $display("FAIL hs_level: got %0d want 3", PI_LEVEL); end
    PI_CYCLE = 1'b1;
    tick();
    PI_CYCLE = 1'b0;
    n_vec++;
    if (EBUS_CP_GRANT !== 1'b1 || READY !== 1'b0) begin
      n_err++;
      $display("FAIL hs_grant: grant=%b ready=%b want 1 0", EBUS_CP_GRANT, READY);
    end
    tick(); tick();
    IO_ACK = 1'b1;
    tick();
    IO_ACK = 1'b0;
    n_vec++;
    if (EXT_TRAN_REC !== 1'b1) begin n_err++; $display("FAIL hs_etr_pulse: got %b want 1", EXT_TRAN_REC); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (EXT_TRAN_REC !== 1'b0) etr_extra = 1'b1;
    end
    n_vec++;
    if (etr_extra || EBUS_CP_GRANT !== 1'b1) begin
      n_err++;
      $display("FAIL hs_wrel: etr_extra=%b grant=%b want 0 1", etr_extra, EBUS_CP_GRANT);
    end
    EBUS_REL = 1'b1;
    tick();
    EBUS_REL = 1'b0;
    n_vec++;
    if ({EBUS_CP_GRANT, PI_LEVEL, READY} !== 5'b0) begin
      n_err++;
      $display("FAIL hs_release: grant=%b level=%0d ready=%b want 0 0 0", EBUS_CP_GRANT, PI_LEVEL, READY);
    end
    IO_REQ = '0;
  endtask

  task automatic test_pih();
    bit ok;
    bit seen_ready = 1'b0;
    do_reset();
    cono(C25 | C28, ALL);
    IO_REQ = lvl(5);
    wait_ready(12, ok);
    SET_PIH = 1'b1;
    tick();
    SET_PIH = 1'b0;
    n_vec++;
    if (!ok || PIH !== 7'b0000100) begin
      n_err++;
      $display("FAIL pih_set5: ready_ok=%b PIH=%b want 1 0000100", ok, PIH);
    end
    IO_REQ = lvl(5) | lvl(6);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i > 1 && READY !== 1'b0) seen_ready = 1'b1;
    end
    n_vec++;
    if (seen_ready || PI_LEVEL !== 3'd0) begin
      n_err++;
      $display("FAIL pih_block: ready_seen=%b level=%0d want 0 0", seen_ready, PI_LEVEL);
    end
    IO_REQ = lvl(2) | lvl(5) | lvl(6);
    wait_ready(12, ok);
    n_vec++;
    if (!ok || PI_LEVEL !== 3'd2) begin
      n_err++;
      $display("FAIL pih_level2: ready_ok=%b level=%0d want 1 2", ok, PI_LEVEL);
    end
    SET_PIH = 1'b1;
    tick();
    SET_PIH = 1'b0;
    n_vec++;
    if (PIH !== 7'b0100100) begin n_err++; $display("FAIL pih_set2: PIH=%b want 0100100", PIH); end
    PI_DISMISS = 1'b1;
    tick();
    PI_DISMISS = 1'b0;
    n_vec++;
    if (PIH !== 7'b0000100) begin n_err++; $display("FAIL pih_dismiss: PIH=%b want 0000100", PIH); end
    IO_REQ = '0;
  endtask

  task automatic test_timeout();
    bit ok;
    bit etr_seen = 1'b0;
    int grant_cycles = 0;
    do_reset();
    cono(C25 | C28, ALL);
    IO_REQ = lvl(1);
    wait_ready(12, ok);
    PI_CYCLE = 1'b1;
    tick();
    PI_CYCLE = 1'b0;
    IO_REQ = '0;
    for (int i = 0; i < 40; i++) begin
      if (NO_RESP === 1'b1) break;
      if (EBUS_CP_GRANT === 1'b1) grant_cycles++;
      if (EXT_TRAN_REC !== 1'b0) etr_seen = 1'b1;
      tick();
    end
    n_vec++;
    if (!ok || NO_RESP !== 1'b1 || grant_cycles != 16) begin
      n_err++;
      $display("FAIL to_count: ready_ok=%b NO_RESP=%b grant_cycles=%0d want 1 1 16", ok, NO_RESP, grant_cycles);
    end
    n_vec++;
    if (etr_seen || EXT_TRAN_REC !== 1'b0 || EBUS_CP_GRANT !== 1'b1) begin
      n_err++;
      $display("FAIL to_no_etr: etr_seen=%b grant=%b want 0 1", etr_seen, EBUS_CP_GRANT);
    end
    cono(C22, '0);
    n_vec++;
    if ({NO_RESP, EBUS_CP_GRANT, READY, PI_LEVEL, PI_ON, LEVEL_ON, PIR, PIH} !== '0) begin
      n_err++;
      $display("FAIL to_clear22: state=%b want all 0",
               {NO_RESP, EBUS_CP_GRANT, READY, PI_LEVEL, PI_ON, LEVEL_ON, PIR, PIH});
    end
  endtask

  task automatic test_preempt();
    bit ok;
    bit dropped = 1'b0;
    do_reset();
    cono(C25 | C28, ALL);
    IO_REQ = lvl(4);
    wait_ready(12, ok);
    n_vec++;
    if (!ok || PI_LEVEL !== 3'd4) begin
      n_err++;
      $display("FAIL pre_level4: ready_ok=%b level=%0d want 1 4", ok, PI_LEVEL);
    end
    IO_REQ = lvl(1) | lvl(4);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (READY !== 1'b1) dropped = 1'b1;
      else if (dropped) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!dropped || !ok || PI_LEVEL !== 3'd1) begin
      n_err++;
      $display("FAIL pre_level1: dropped=%b reready=%b level=%0d want 1 1 1", dropped, ok, PI_LEVEL);
    end
    IO_REQ = lvl(1);
    tick(); tick();
    IO_REQ = '0;
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (READY !== 1'b0 || PI_LEVEL !== 3'd0) begin
      n_err++;
      $display("FAIL pre_drop: ready=%b level=%0d want 0 0", READY, PI_LEVEL);
    end
  endtask

  task automatic test_pir_grant();
    bit ok;
    do_reset();
    cono(C25 | C28, ALL);
    cono(C24, lvl(6));
    n_vec++;
    if (PIR !== lvl(6)) begin n_err++; $display("FAIL pir_set: PIR=%b want %b", PIR, lvl(6)); end
    wait_ready(12, ok);
    n_vec++;
    if (!ok || PI_LEVEL !== 3'd6) begin
      n_err++;
      $display("FAIL pir_level: ready_ok=%b level=%0d want 1 6", ok, PI_LEVEL);
    end
    SET_PIH = 1'b1;
    tick();
    SET_PIH = 1'b0;
    n_vec++;
    if (PIR !== 7'b0 || PIH !== lvl(6)) begin
      n_err++;
      $display("FAIL pir_to_pih: PIR=%b PIH=%b want 0000000 %b", PIR, PIH, lvl(6));
    end
  endtask

  task automatic test_disable();
    bit seen = 1'b0;
    bit ok;
    do_reset();
    PI_DISABLE = 1'b1;
    cono(C25 | C28, ALL);
    IO_REQ = lvl(3);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (READY !== 1'b0) seen = 1'b1;
    end
    PI_DISABLE = 1'b0;
    wait_ready(8, ok);
    n_vec++;
    if (seen || !ok || PI_LEVEL !== 3'd3) begin
      n_err++;
      $display("FAIL dis_block: ready_while_disabled=%b ready_ok=%b level=%0d want 0 1 3", seen, ok, PI_LEVEL);
    end
    IO_REQ = '0;
  endtask

  task automatic test_cono_random();
    logic [22:28] c;
    logic [1:7]   sel, m_pir, m_lon;
    logic         m_on;
    do_reset();
    m_pir = '0; m_lon = '0; m_on = 1'b0;
    for (int k = 0; k < 20; k++) begin
      c = 7'($urandom);
      c[22] = 1'b0;
      sel = 7'($urandom);
      cono(c, sel);
      for (int n = 1; n <= 7; n++) begin
        if (c[24] && sel[n]) m_pir[n] = 1'b1;
        else if (c[23]) m_pir[n] = 1'b0;
        if (c[26] && sel[n]) m_lon[n] = 1'b0;
        else if (c[25] && sel[n]) m_lon[n] = 1'b1;
      end
      if (c[27]) m_on = 1'b0;
      else if (c[28]) m_on = 1'b1;
      n_vec++;
      if (PIR !== m_pir || LEVEL_ON !== m_lon || PI_ON !== m_on || PIH !== 7'b0) begin
        n_err++;
        $display("FAIL cono_rand[%0d]: ctl=%b sel=%b PIR=%b LON=%b ON=%b PIH=%b want %b %b %b 0000000",
                 k, c, sel, PIR, LEVEL_ON, PI_ON, PIH, m_pir, m_lon, m_on);
      end
    end
    cono(C22, '0);
    n_vec++;
    if ({PIR, LEVEL_ON, PI_ON} !== '0) begin
      n_err++;
      $display("FAIL cono_clear: PIR=%b LON=%b ON=%b want 0", PIR, LEVEL_ON, PI_ON);
    end
  endtask

  task automatic test_priority_random();
    logic [1:7] io, pr, lv, elig;
    int want;
    bit ok;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      io = 7'($urandom);
      pr = 7'($urandom) & 7'($urandom);
      lv = 7'($urandom) | 7'($urandom);
      cono(C22, '0);
      IO_REQ = io;
      cono(C24, pr);
      tick(); tick();
      cono(C25 | C28, lv);
      elig = (io | pr) & lv;
      want = 0;
      for (int n = 1; n <= 7; n++) begin
        if (elig[n]) begin want = n; break; end
      end
      wait_ready(8, ok);
      n_vec++;
      if (want == 0) begin
        if (ok || PI_LEVEL !== 3'd0) begin
          n_err++;
          $display("FAIL prio_rand[%0d]: io=%b pir=%b lon=%b ready=%b level=%0d want 0 0", k, io, pr, lv, READY, PI_LEVEL);
        end
      end else if (!ok || PI_LEVEL !== 3'(want)) begin
        n_err++;
        $display("FAIL prio_rand[%0d]: io=%b pir=%b lon=%b ready=%b level=%0d want 1 %0d", k, io, pr, lv, READY, PI_LEVEL, want);
      end
    end
    IO_REQ = '0;
    cono(C22, '0);
  endtask

  task automatic test_async_reset();
    bit ok;
    bit spurious = 1'b0;
    do_reset();
    cono(C25 | C28, ALL);
    IO_REQ = lvl(2);
    wait_ready(12, ok);
    PI_CYCLE = 1'b1;
    tick();
    PI_CYCLE = 1'b0;
    IO_ACK = 1'b1;
    tick();
    IO_ACK = 1'b0;
    n_vec++;
    if (!ok || EBUS_CP_GRANT !== 1'b1) begin
      n_err++;
      $display("FAIL ar_wrel: ready_ok=%b grant=%b want 1 1", ok, EBUS_CP_GRANT);
    end
    #2;
    RESET = 1'b1;
    #1;
    n_vec++;
    if ({READY, PI_LEVEL, EBUS_CP_GRANT, EXT_TRAN_REC, NO_RESP, PI_ON, LEVEL_ON, PIR, PIH} !== '0) begin
      n_err++;
      $display("FAIL ar_immediate: outputs=%b want all 0",
               {READY, PI_LEVEL, EBUS_CP_GRANT, EXT_TRAN_REC, NO_RESP, PI_ON, LEVEL_ON, PIR, PIH});
    end
    #2;
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (READY !== 1'b0 || EBUS_CP_GRANT !== 1'b0) spurious = 1'b1;
    end
    n_vec++;
    if (spurious) begin n_err++; $display("FAIL ar_after: spurious READY/grant=%b want 0", spurious); end
    IO_REQ = '0;
  endtask

  initial begin
    RESET = 1'b0;
    CONO_PI = 0; EBUS_DATA = '0; IO_REQ = '0; IO_ACK = 0; PI_DISABLE = 0;
    PI_CYCLE = 0; SET_PIH = 0; PI_DISMISS = 0; EBUS_REL = 0;
    #1 RESET = 1'b1;
    #2;
    test_reset();
    test_handshake();
    test_pih();
    test_timeout();
    test_preempt();
    test_pir_grant();
    test_disable();
    test_cono_random();
    test_priority_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
